// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing the GPIO controller register port between a CPU master (m0)
// and a pattern/DMA master (m1). One transaction in flight; read data returned to its owner.
module gpio_bus_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [DATA_W-1:0] dn_wdata,
  output logic              dn_we,
  output logic              dn_re,
  input  logic [DATA_W-1:0] dn_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a master holds req with stable fields until its gnt pulse; gnt means the
  // strobes are on the controller port that same cycle. rvalid pulses once with rdata.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t state;
  logic   owner;       // 0 = m0, 1 = m1
  logic   last_grant;

  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // m1 wins when it is alone, or when both ask and m0 was granted last.
  assign pick      = m1_req && (!m0_req || !last_grant);
  assign sel_we    = pick ? m1_we    : m0_we;
  assign sel_addr  = pick ? m1_addr  : m0_addr;
  assign sel_wdata = pick ? m1_wdata : m0_wdata;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      dn_addr    <= '0;
      dn_wdata   <= '0;
      dn_we      <= 1'b0;
      dn_re      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner      <= pick;
            last_grant <= pick;
            dn_addr    <= sel_addr;
            dn_wdata   <= sel_wdata;
            dn_we      <= sel_we;
            dn_re      <= ~sel_we;
            m0_gnt     <= ~pick;
            m1_gnt     <= pick;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          dn_we <= 1'b0;
          dn_re <= 1'b0;
          if (dn_re) begin
            state <= RDWAIT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RDWAIT: begin
          if (owner) begin
            m1_rdata  <= dn_rdata;
            m1_rvalid <= 1'b1;
          end else begin
            m0_rdata  <= dn_rdata;
            m0_rvalid <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          dn_we <= 1'b0;
          dn_re <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter with a small model of the GPIO controller register port.
module tb_gpio_bus_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] dn_addr;
  logic [DATA_W-1:0] dn_wdata;
  logic              dn_we, dn_re, busy;
  logic [DATA_W-1:0] dn_rdata = '0;
  logic [1:0]        dbg_state;

  gpio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .dn_addr(dn_addr), .dn_wdata(dn_wdata), .dn_we(dn_we), .dn_re(dn_re),
    .dn_rdata(dn_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // GPIO controller model: out 0x0, in 0x4, dir 0x8; rdata registered one cycle after re.
  logic [9:0] gpio_out = '0, gpio_dir = '0;
  localparam logic [9:0] GPIO_IN = 10'h2B5;
  always @(posedge clk) begin
    if (dn_we) begin
      if (dn_addr == 4'h0) gpio_out <= dn_wdata[9:0];
      if (dn_addr == 4'h8) gpio_dir <= dn_wdata[9:0];
    end
    if (dn_re) begin
      case (dn_addr)
        4'h0:    dn_rdata <= {22'd0, gpio_out};
        4'h4:    dn_rdata <= {22'd0, GPIO_IN};
        4'h8:    dn_rdata <= {22'd0, gpio_dir};
        default: dn_rdata <= '0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Exclusivity invariants checked every cycle.
  always @(negedge clk) begin
    check("exclusive", {29'd0, dn_we & dn_re, m0_gnt & m1_gnt, m0_rvalid & m1_rvalid}, 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_req = 0;
    m1_req = 0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic m0_drive(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic m1_drive(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  task automatic m0_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    m0_drive(1'b1, a, d);
    tick();
    m0_req = 0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    #1;
    check("rst_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    check("rst_strobes", {29'd0, dn_we, dn_re, busy}, 32'd0);
    check("rst_addr", {28'd0, dn_addr}, 32'd0);
    check("rst_wdata", dn_wdata, 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    tick();
    rst_n = 1'b1;

    // m0 write dir = 0x3FF
    m0_drive(1'b1, 4'h8, 32'h3FF);
    tick();
    m0_req = 0;
    check("w_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
    check("w_we_re_busy", {29'd0, dn_we, dn_re, busy}, 32'h5);
    check("w_addr", {28'd0, dn_addr}, 32'h8);
    check("w_wdata", dn_wdata, 32'h3FF);
    tick();
    check("w_done", {29'd0, dn_we, dn_re, busy}, 32'd0);
    check("w_gnt_drop", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    check("w_addr_hold", {28'd0, dn_addr}, 32'h8);
    check("w_dir_model", {22'd0, gpio_dir}, 32'h3FF);

    // m1 read of out register holding 0x155
    m0_write(4'h0, 32'h155);
    m1_drive(1'b0, 4'h0, 32'h0);
    tick();
    m1_req = 0;
    check("r_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd1);
    check("r_re", {30'd0, dn_we, dn_re}, 32'd1);
    tick();
    check("r_wait_state", {30'd0, dbg_state}, 32'd2);
    check("r_wait_busy", {29'd0, busy, dn_re, m1_rvalid}, 32'h4);
    tick();
    exp_q.push_back(32'h155);
    check("r_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd1);
    check("r_rdata", m1_rdata, exp_q.pop_front());
    check("r_m0_rdata", m0_rdata, 32'd0);
    check("r_busy", {31'd0, busy}, 32'd0);
    tick();
    check("r_rvalid_drop", {31'd0, m1_rvalid}, 32'd0);
    check("r_rdata_hold", m1_rdata, 32'h155);

    // Contention: both hold writes; grants m0,m1,m0,m1 every second cycle
    do_reset();
    m0_drive(1'b1, 4'h0, 32'h0AA);
    m1_drive(1'b1, 4'h8, 32'h3C3);
    for (int k = 1; k <= 8; k++) begin
      tick();
      case (k)
        1, 5:    check($sformatf("rr_gnt_%0d", k), {30'd0, m0_gnt, m1_gnt}, 32'd2);
        3, 7:    check($sformatf("rr_gnt_%0d", k), {30'd0, m0_gnt, m1_gnt}, 32'd1);
        default: check($sformatf("rr_gnt_%0d", k), {30'd0, m0_gnt, m1_gnt}, 32'd0);
      endcase
      if (k == 3) check("rr_m1_wdata", dn_wdata, 32'h3C3);
    end
    m0_req = 0;
    m1_req = 0;
    tick();
    check("rr_idle", {30'd0, dbg_state}, 32'd0);

    // m0 request arriving while m1 read is in flight
    m1_drive(1'b0, 4'h8, 32'h0);
    tick();
    m1_req = 0;
    m0_drive(1'b1, 4'h0, 32'h02A);
    check("wt_m1_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd1);
    tick();
    check("wt_rdwait_nogrant", {30'd0, m0_gnt, dbg_state}, 32'd2);
    tick();
    check("wt_rvalid", {30'd0, m1_rvalid, m0_gnt}, 32'd2);
    check("wt_rdata", m1_rdata, 32'h3C3);
    check("wt_m0_rdata", m0_rdata, 32'd0);
    tick();
    m0_req = 0;
    check("wt_m0_gnt", {30'd0, m0_gnt, m1_rvalid}, 32'd2);
    tick();
    check("wt_out_model", {22'd0, gpio_out}, 32'h02A);

    // Asynchronous reset during ACCESS of a read
    m0_drive(1'b0, 4'h0, 32'h0);
    tick();
    m0_req = 0;
    check("ar_pre", {29'd0, dn_re, m0_gnt, busy}, 32'h7);
    #2 rst_n = 1'b0;
    #1;
    check("ar_clear", {28'd0, dn_re, m0_gnt, busy, dbg_state[0]}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ar_no_rvalid_%0d", k), {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    end
    m0_drive(1'b1, 4'h0, 32'h011);
    m1_drive(1'b1, 4'h8, 32'h022);
    tick();
    m0_req = 0;
    m1_req = 0;
    check("ar_contend_m0", {30'd0, m0_gnt, m1_gnt}, 32'd2);
    tick();
    tick();

    // Back-to-back reads by m0 (out reg, then unmapped 0xC): 6 cycles
    m0_drive(1'b0, 4'h0, 32'h0);
    tick();
    check("bb_gnt1", {31'd0, m0_gnt}, 32'd1);
    m0_addr = 4'hC;
    tick();
    tick();
    check("bb_rvalid1", {31'd0, m0_rvalid}, 32'd1);
    check("bb_rdata1", m0_rdata, 32'h011);
    tick();
    m0_req = 0;
    check("bb_gnt2", {31'd0, m0_gnt}, 32'd1);
    check("bb_addr2", {28'd0, dn_addr}, 32'hC);
    tick();
    check("bb_mid", {31'd0, m0_rvalid}, 32'd0);
    tick();
    check("bb_rvalid2", {30'd0, m0_rvalid, busy}, 32'd2);
    check("bb_rdata2", m0_rdata, 32'd0);
    check("bb_m1_rdata", m1_rdata, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
